gauss_kernel_dotprod: RTL and testbench
=======================================

// Module: gauss_kernel_dotprod
// PURPOSE
//   11-tap 1-D Gaussian smoothing dot product for the image convolution datapath.
//   - Multiplies an 11-pixel window by a symmetric Gaussian kernel.
//   - The kernel is chosen from 8 fixed sets by a 3-bit sigma code.
//   - Returns one rounded 8-bit pixel.
//   - Used for the separable row and column passes of the blur.
// PARAMETERS
//   none. Widths and coefficients are fixed constants in gauss_kernel_pkg.
// PORTS
//   clk    in   1      single clock; all state updates on the rising edge
//   rst_n  in   1      reset, asynchronous and active-low
//   sigma  in   3      kernel select code 0..7
//   din    in   8x[11] unpacked array din[10:0] of 8-bit unsigned pixels; din[5] = centre tap
//   dout   out  8      filtered pixel, unsigned
// BEHAVIOUR
//   Reset
//     - While rst_n=0, all pipeline registers and dout are 0.
//     - Reset takes effect immediately, asynchronously.
//     - Reset in mid-stream discards in-flight data; the first valid output comes 2 edges after release.
//   Pipeline (default latency 2)
//     - Edge 1: register din and sigma.
//     - Edge 2: register dout computed from the registered values.
//     - A new input is accepted every cycle. There is no handshake and no valid signal.
//   Kernel
//     - coef[s][i] is 9-bit unsigned, 0..256, and symmetric: coef[s][i] = coef[s][10-i].
//     - For every s, the 11 taps sum to exactly 256.
//     - s=0: identity kernel. Centre tap = 256, all others 0, so dout = din[5].
//     - s=1..7: Gaussian with sigma_val = 0.5*s, tap offset k = i-5.
//       - g_k = exp(-k^2 / (2*sigma_val^2)).
//       - Each non-centre tap = round(256*g_k / sum(g)).
//       - Centre tap = 256 minus the sum of the other 10 taps.
//   Arithmetic
//     - acc = sum over i of din[i]*coef[s][i]. Products are 17 bits; acc is a 20-bit unsigned accumulator.
//     - dout = (acc + 128) >> 8, i.e. round half up.
//     - The result saturates at 255. Saturation is unreachable for valid tables but is still implemented.
//     - A constant input window returns the same value for every sigma, with no rounding drift.
//   Sigma change
//     - sigma may change every cycle.
//     - Each output uses the sigma registered together with its own din.
// CONFIGURATION
//   GAUSS_DOTPROD_PIPE_EN
//     - Defined: adds one register stage between the 11 products and the adder tree. Latency = 3.
//     - Undefined: products and sum are combinational in stage 2. Latency = 2.
//     - Numeric results are identical either way. Only latency changes.
//     - Reset clears the extra stage too.
// STRUCTURE
//   gauss_kernel_pkg holds:
//     - NTAPS=11, PIX_W=8, COEF_W=9, ACC_W=20.
//     - typedef pix_t (logic [7:0]) and typedef coef_t (logic [8:0]).
//     - The constant half-kernel table COEF[8][6], taps 0..5, tap 5 = centre. The other half is mirrored.
//   Sub-module gauss_coef_rom:
//     - Combinational.
//     - Takes sigma and returns the full 11-entry coef_t array from the package table.
//   Top level: input registers, 11 multipliers, adder tree, round/saturate, output register.
// TESTING
//   - Reset: hold rst_n=0 with din all 0xFF -> dout=0x00. After release and 2 edges -> dout=0xFF.
//   - Constant window: din all 0xFF, sweep sigma 0..7 -> dout=0xFF for each. Repeat with all 0x7F -> 0x7F.
//   - Identity: sigma=0 with din[10:0] = {0x0C,0xC6,0x1E,0x8E,0xAC,0xE1,0xE3,0xDC,0xF6,0x81,0x86}
//     -> dout=0xE1.
//   - Mixed window: same din as above, sigma 1..7 -> dout matches the golden model (acc+128)>>8 bit-exactly.
//   - Impulse: din[5]=0xFF, others 0, sigma=s -> dout = (255*coef[s][5] + 128) >> 8.
//   - Streaming: change sigma and din every cycle -> outputs appear in order with the stated latency,
//     checked with and without GAUSS_DOTPROD_PIPE_EN.

Source files
------------

// File: rtl/gauss_kernel_pkg.sv
// Shared widths, types, Gaussian half-kernel table and output rounding for the
// 11-tap smoothing dot product.
package gauss_kernel_pkg;

  localparam int unsigned NTAPS  = 11;
  localparam int unsigned HALF   = 6;
  localparam int unsigned NSIG   = 8;
  localparam int unsigned SIG_W  = 3;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned COEF_W = 9;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned SHIFT  = 8;
  localparam int unsigned Q_W    = ACC_W - SHIFT + 1;
  localparam int unsigned RND    = 128;
  localparam int unsigned PIX_MAX = 255;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [ACC_W:0]    accx_t;
  typedef logic [Q_W-1:0]    quot_t;

  // Taps 0..5 per sigma code; tap 5 is the centre, taps 6..10 mirror 4..0.
  localparam coef_t COEF [NSIG][HALF] = '{
    '{9'd0,  9'd0,  9'd0,  9'd0,  9'd0,  9'd256},
    '{9'd0,  9'd0,  9'd0,  9'd0,  9'd27, 9'd202},
    '{9'd0,  9'd0,  9'd1,  9'd14, 9'd62, 9'd102},
    '{9'd0,  9'd2,  9'd9,  9'd28, 9'd55, 9'd68},
    '{9'd2,  9'd7,  9'd17, 9'd31, 9'd45, 9'd52},
    '{9'd6,  9'd12, 9'd20, 9'd30, 9'd39, 9'd42},
    '{9'd9,  9'd15, 9'd22, 9'd29, 9'd34, 9'd38},
    '{9'd12, 9'd17, 9'd23, 9'd28, 9'd32, 9'd32}
  };

  // Round half up by 1/256 and clamp to the pixel range.
  function automatic pix_t round_sat(input acc_t acc);
    accx_t sum;
    quot_t q;
    sum = accx_t'(acc) + accx_t'(RND);
    q   = sum[ACC_W:SHIFT];
    return (q > quot_t'(PIX_MAX)) ? pix_t'(PIX_MAX) : q[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/gauss_coef_rom.sv
// Combinational kernel lookup: expands the stored half-kernel for a sigma code
// into all 11 symmetric taps.
module gauss_coef_rom
  import gauss_kernel_pkg::*;
(
  input  logic [SIG_W-1:0] sigma,
  output coef_t            coef_c [NTAPS-1:0]
);

  for (genvar i = 0; i < NTAPS; i++) begin : g_tap
    localparam int unsigned SRC = (i < HALF) ? i : NTAPS - 1 - i;
    assign coef_c[i] = COEF[sigma][SRC];
  end

endmodule

// File: rtl/gauss_kernel_dotprod.sv
// 11-tap Gaussian dot product with rounded, saturated 8-bit output.
// GAUSS_DOTPROD_PIPE_EN adds a product register stage (latency 3 instead of 2).
module gauss_kernel_dotprod
  import gauss_kernel_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SIG_W-1:0] sigma,
  input  logic [PIX_W-1:0] din [NTAPS-1:0],
  output logic [PIX_W-1:0] dout
);

  pix_t             din_d   [NTAPS-1:0];
  pix_t             din_q   [NTAPS-1:0];
  logic [SIG_W-1:0] sigma_d;
  logic [SIG_W-1:0] sigma_q;
  coef_t            coef_c  [NTAPS-1:0];
  prod_t            prod_c  [NTAPS-1:0];
  prod_t            prod_s  [NTAPS-1:0];
  acc_t             acc_c;
  pix_t             dout_d;
  pix_t             dout_q;

  always_comb begin
    din_d   = din;
    sigma_d = sigma;
  end

  // Input stage: window and its sigma travel together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) din_q[i] <= '0;
      sigma_q <= '0;
    end else begin
      din_q   <= din_d;
      sigma_q <= sigma_d;
    end
  end

  gauss_coef_rom u_rom (
    .sigma  (sigma_q),
    .coef_c (coef_c)
  );

  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      prod_c[i] = prod_t'(din_q[i]) * prod_t'(coef_c[i]);
    end
  end

`ifdef GAUSS_DOTPROD_PIPE_EN
  prod_t prod_d [NTAPS-1:0];
  prod_t prod_q [NTAPS-1:0];

  always_comb prod_d = prod_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) prod_q[i] <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  always_comb prod_s = prod_q;
`else
  always_comb prod_s = prod_c;
`endif

  always_comb begin
    acc_c = '0;
    for (int i = 0; i < NTAPS; i++) begin
      acc_c = acc_c + acc_t'(prod_s[i]);
    end
    dout_d = round_sat(acc_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_gauss_kernel_dotprod.sv
// Self-checking bench for gauss_kernel_dotprod: table vectors, reset corners and
// randomized streaming against a kernel built from the Gaussian formula.
module tb_gauss_kernel_dotprod;

`ifdef GAUSS_DOTPROD_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef logic [10:0][7:0] win_t;

  typedef struct {
    logic [2:0] sigma;
    win_t       win;
    logic [7:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] sigma;
  logic [7:0] din [10:0];
  logic [7:0] dout;

  int nvec;
  int nerr;
  int kern [8][11];

  gauss_kernel_dotprod dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sigma (sigma),
    .din   (din),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Kernel from the Gaussian definition, independent of the RTL table.
  task automatic build_kernel();
    real g [11];
    real sv;
    real sum;
    int  tot;
    for (int s = 0; s < 8; s++) begin
      if (s == 0) begin
        for (int i = 0; i < 11; i++) kern[s][i] = (i == 5) ? 256 : 0;
      end else begin
        sv  = 0.5 * s;
        sum = 0.0;
        for (int i = 0; i < 11; i++) begin
          g[i] = $exp(-1.0 * real'((i - 5) * (i - 5)) / (2.0 * sv * sv));
          sum  = sum + g[i];
        end
        tot = 0;
        for (int i = 0; i < 11; i++) begin
          if (i != 5) begin
            kern[s][i] = $rtoi($floor(256.0 * g[i] / sum + 0.5));
            tot        = tot + kern[s][i];
          end
        end
        kern[s][5] = 256 - tot;
      end
    end
  endtask

  function automatic logic [7:0] golden(input win_t w, input int s);
    int acc;
    int r;
    acc = 0;
    for (int i = 0; i < 11; i++) acc = acc + int'(w[i]) * kern[s][i];
    r = (acc + 128) / 256;
    if (r > 255) r = 255;
    return 8'(r);
  endfunction

  function automatic win_t fill(input logic [7:0] v);
    win_t w;
    for (int i = 0; i < 11; i++) w[i] = v;
    return w;
  endfunction

  task automatic drive(input logic [2:0] s, input win_t w);
    sigma = s;
    for (int i = 0; i < 11; i++) din[i] = w[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] exp);
    nvec++;
    if (dout !== exp) begin
      nerr++;
      $display("FAIL %s: dout=%02h expected %02h", name, dout, exp);
    end
  endtask

  vec_t     tbl [$];
  vec_t     v;
  win_t     mixed;
  win_t     w;
  win_t     imp;
  logic [7:0] expq [$];
  logic [2:0] s;

  initial begin
    nvec  = 0;
    nerr  = 0;
    build_kernel();
    mixed = {8'h0C, 8'hC6, 8'h1E, 8'h8E, 8'hAC, 8'hE1, 8'hE3, 8'hDC, 8'hF6, 8'h81, 8'h86};
    imp   = '0;
    imp[5] = 8'hFF;

    for (int k = 0; k < 8; k++) begin
      v.sigma = 3'(k); v.win = fill(8'hFF); v.exp = 8'hFF; tbl.push_back(v);
    end
    for (int k = 0; k < 8; k++) begin
      v.sigma = 3'(k); v.win = fill(8'h7F); v.exp = 8'h7F; tbl.push_back(v);
    end
    v.sigma = 3'd0; v.win = mixed; v.exp = 8'hE1; tbl.push_back(v);
    for (int k = 1; k < 8; k++) begin
      v.sigma = 3'(k); v.win = mixed; v.exp = golden(mixed, k); tbl.push_back(v);
    end
    for (int k = 0; k < 8; k++) begin
      v.sigma = 3'(k); v.win = imp;
      v.exp = 8'((255 * kern[k][5] + 128) / 256);
      tbl.push_back(v);
    end

    // Reset with a saturated window pending at the inputs.
    rst_n = 1'b0;
    drive(3'd0, fill(8'hFF));
    #2;
    chk("reset_async", 8'h00);
    tick();
    tick();
    chk("reset_hold", 8'h00);
    rst_n = 1'b1;
    for (int k = 0; k < LAT - 1; k++) begin
      tick();
      chk("reset_fill", 8'h00);
    end
    tick();
    chk("reset_first", 8'hFF);

    foreach (tbl[k]) begin
      drive(tbl[k].sigma, tbl[k].win);
      repeat (LAT) tick();
      chk($sformatf("vec%0d_s%0d", k, tbl[k].sigma), tbl[k].exp);
    end

    // Streaming: new sigma and window every cycle.
    expq.delete();
    for (int n = 0; n < 300; n++) begin
      s = 3'($urandom_range(0, 7));
      for (int i = 0; i < 11; i++) w[i] = 8'($urandom_range(0, 255));
      if (n % 37 == 5) w = fill(8'($urandom_range(0, 255)));
      drive(s, w);
      expq.push_back(golden(w, int'(s)));
      tick();
      if (expq.size() == LAT) chk($sformatf("stream%0d", n), expq.pop_front());
    end

    // Reset in mid-stream drops in-flight data.
    drive(3'd4, mixed);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_async", 8'h00);
    tick();
    chk("midreset_hold", 8'h00);
    rst_n = 1'b1;
    drive(3'd7, mixed);
    for (int k = 0; k < LAT - 1; k++) begin
      tick();
      chk("midreset_fill", 8'h00);
    end
    tick();
    chk("midreset_first", golden(mixed, 7));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
